viterbi_step_ctrl: RTL and testbench

//  Sequences the rate-1/2 BMC/ACS array, one trellis step per accepted rx_pair.

---
 rtl/viterbi_pkg.sv | 18 +
 rtl/viterbi_step_ctrl.sv | 110 +++++++++++
 tb/tb_viterbi_step_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants and types for the Viterbi step controller and the BMC/ACS array.
package viterbi_pkg;

  localparam int DEF_FRAME_LEN   = 64;
  localparam int DEF_PM_W        = 8;
  localparam int DEF_NORM_THRESH = 128;

  // Metric loaded into every non-zero state at frame start; shared with acs_*.
  localparam logic [DEF_PM_W-1:0] ACS_INIT_MAX = {DEF_PM_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INIT    = 2'd1,
    RUN     = 2'd2,
    HANDOFF = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/viterbi_step_ctrl.sv
// Rate-1/2 trellis step sequencer: takes one rx_pair per step, drives the BMC/ACS
// array, requests metric normalisation and hands each finished frame to traceback.
//
// state   | meaning
// IDLE    | waiting for the first symbol of a frame (not consumed here)
// INIT    | one-cycle ACS metric initialisation, step counter cleared
// RUN     | accepting pairs, one ACS update per accepted pair
// HANDOFF | last step issued, tb_req held until tb_ack
module viterbi_step_ctrl
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN   = DEF_FRAME_LEN,
  parameter int PM_W        = DEF_PM_W,
  parameter int NORM_THRESH = DEF_NORM_THRESH,
  parameter int CNT_W       = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       rx_pair_in,
  output logic [1:0]       rx_pair,
  output logic             acs_init,
  output logic             acs_en,
  output logic             norm_en,
  input  logic [PM_W-1:0]  pm_min,
  output logic [CNT_W-1:0] step_cnt,
  output logic             tb_req,
  input  logic             tb_ack,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [PM_W-1:0]  THRESH   = PM_W'(NORM_THRESH);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [1:0]       rx_pair_q, rx_pair_d;
  logic             acs_en_q, acs_en_d;
  logic             in_ready_c;
  logic             accept;
  logic             tb_req_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_cnt_q  <= '0;
      step_cnt_q <= '0;
      rx_pair_q  <= '0;
      acs_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_cnt_q  <= acc_cnt_d;
      step_cnt_q <= step_cnt_d;
      rx_pair_q  <= rx_pair_d;
      acs_en_q   <= acs_en_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_cnt_d  = acc_cnt_q;
    step_cnt_d = step_cnt_q;
    rx_pair_d  = rx_pair_q;
    acs_en_d   = 1'b0;
    in_ready_c = (state_q == RUN);
    accept     = in_valid & in_ready_c;
    // The last step's ACS update occupies the first HANDOFF cycle.
    tb_req_c   = (state_q == HANDOFF) && !acs_en_q;

    case (state_q)
      IDLE: begin
        if (in_valid) state_d = INIT;
      end
      INIT: begin
        acc_cnt_d  = '0;
        step_cnt_d = '0;
        state_d    = RUN;
      end
      RUN: begin
        if (accept) begin
          rx_pair_d  = rx_pair_in;
          acs_en_d   = 1'b1;
          step_cnt_d = acc_cnt_q;
          if (acc_cnt_q == LAST_IDX) begin
            state_d = HANDOFF;
          end else begin
            acc_cnt_d = acc_cnt_q + 1'b1;
          end
        end
      end
      HANDOFF: begin
        if (tb_req_c && tb_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready = in_ready_c;
  assign rx_pair  = rx_pair_q;
  assign acs_init = (state_q == INIT);
  assign acs_en   = acs_en_q;
  assign step_cnt = step_cnt_q;
  assign tb_req   = tb_req_c;
  assign busy     = (state_q != IDLE);
  // Step 0 follows straight after init, so metrics cannot need normalising yet.
  assign norm_en  = acs_en_q && (pm_min >= THRESH) && (step_cnt_q != '0);

endmodule

// File: tb/tb_viterbi_step_ctrl.sv
// Directed bench for viterbi_step_ctrl with hand-computed expectations.
module tb_viterbi_step_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] rx_pair_in;
  logic [1:0] rx_pair;
  logic       acs_init;
  logic       acs_en;
  logic       norm_en;
  logic [7:0] pm_min;
  logic [5:0] step_cnt;
  logic       tb_req;
  logic       tb_ack;
  logic       busy;

  int errors = 0;
  int checks = 0;

  viterbi_step_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rx_pair_in (rx_pair_in),
    .rx_pair    (rx_pair),
    .acs_init   (acs_init),
    .acs_en     (acs_en),
    .norm_en    (norm_en),
    .pm_min     (pm_min),
    .step_cnt   (step_cnt),
    .tb_req     (tb_req),
    .tb_ack     (tb_ack),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 0);
    chk({tag, ".rx_pair"},  32'(rx_pair),  0);
    chk({tag, ".acs_init"}, 32'(acs_init), 0);
    chk({tag, ".acs_en"},   32'(acs_en),   0);
    chk({tag, ".norm_en"},  32'(norm_en),  0);
    chk({tag, ".step_cnt"}, 32'(step_cnt), 0);
    chk({tag, ".tb_req"},   32'(tb_req),   0);
    chk({tag, ".busy"},     32'(busy),     0);
  endtask

  function automatic logic [1:0] pat(input int i);
    return 2'((i * 3 + 1) % 4);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; rx_pair_in = 2'b00; pm_min = 8'd0; tb_ack = 1'b0;
    // 1: reset
    for (int i = 0; i < 3; i++) tick();
    chk_all_zero("rst_held");
    rst = 1'b0;
    tick();
    chk_all_zero("rst_rel");

    // 2: full-rate frame
    in_valid = 1'b1;
    rx_pair_in = pat(0);
    chk("idle_ready", 32'(in_ready), 0);
    tick();
    chk("f1_init", 32'(acs_init), 1);
    chk("f1_init_rdy", 32'(in_ready), 0);
    chk("f1_init_busy", 32'(busy), 1);
    tick();
    chk("f1_run_init", 32'(acs_init), 0);
    chk("f1_run_rdy", 32'(in_ready), 1);
    chk("f1_run_en", 32'(acs_en), 0);
    for (int i = 0; i < 64; i++) begin
      rx_pair_in = pat(i);
      tick();
      chk("f1_en", 32'(acs_en), 1);
      chk("f1_step", 32'(step_cnt), 32'(i));
      chk("f1_pair", 32'(rx_pair), 32'(pat(i)));
      chk("f1_noinit", 32'(acs_init), 0);
      chk("f1_rdy", 32'(in_ready), (i < 63) ? 1 : 0);
      chk("f1_noreq", 32'(tb_req), 0);
    end
    in_valid = 1'b0;

    // 3: tb_ack ignored before tb_req, then delayed 10 cycles
    tb_ack = 1'b1;
    tick();
    tb_ack = 1'b0;
    chk("f1_early_ack_busy", 32'(busy), 1);
    chk("f1_req_first", 32'(tb_req), 1);
    chk("f1_en_off", 32'(acs_en), 0);
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("f1_req_hold", 32'(tb_req), 1);
      chk("f1_req_rdy", 32'(in_ready), 0);
      chk("f1_req_pair", 32'(rx_pair), 32'(pat(63)));
    end
    tb_ack = 1'b1;
    tick();
    tb_ack = 1'b0;
    chk("f1_ack_req", 32'(tb_req), 0);
    chk("f1_ack_busy", 32'(busy), 0);
    chk("f1_ack_rdy", 32'(in_ready), 0);

    // 4/5: gapped frame with normalisation thresholds
    pm_min = 8'd200;
    in_valid = 1'b1;
    tick();
    chk("f2_init", 32'(acs_init), 1);
    chk("f2_init_norm", 32'(norm_en), 0);
    tick();
    rx_pair_in = 2'b10;
    tick();
    chk("f2_s0_en", 32'(acs_en), 1);
    chk("f2_s0_step", 32'(step_cnt), 0);
    chk("f2_s0_pair", 32'(rx_pair), 32'h2);
    chk("f2_s0_norm", 32'(norm_en), 0);
    in_valid = 1'b0; rx_pair_in = 2'b01;
    tick();
    chk("f2_gap0_en", 32'(acs_en), 0);
    chk("f2_gap0_step", 32'(step_cnt), 0);
    chk("f2_gap0_pair", 32'(rx_pair), 32'h2);
    chk("f2_gap0_norm", 32'(norm_en), 0);
    in_valid = 1'b1; rx_pair_in = 2'b11;
    tick();
    chk("f2_s1_en", 32'(acs_en), 1);
    chk("f2_s1_step", 32'(step_cnt), 1);
    chk("f2_s1_pair", 32'(rx_pair), 32'h3);
    chk("f2_s1_norm", 32'(norm_en), 1);
    in_valid = 1'b0;
    tick();
    chk("f2_gap1_en", 32'(acs_en), 0);
    chk("f2_gap1_step", 32'(step_cnt), 1);
    in_valid = 1'b1; rx_pair_in = 2'b00;
    tick();
    pm_min = 8'd127;
    #1;
    chk("f2_s2_step", 32'(step_cnt), 2);
    chk("f2_norm127", 32'(norm_en), 0);
    rx_pair_in = 2'b01;
    tick();
    pm_min = 8'd128;
    #1;
    chk("f2_s3_step", 32'(step_cnt), 3);
    chk("f2_norm128", 32'(norm_en), 1);
    in_valid = 1'b0;
    tick();
    pm_min = 8'd200;
    #1;
    chk("f2_idle_en", 32'(acs_en), 0);
    chk("f2_norm_noen", 32'(norm_en), 0);

    // 6: abort at step 30
    pm_min = 8'd0;
    in_valid = 1'b1;
    for (int i = 4; i <= 30; i++) begin
      rx_pair_in = pat(i);
      tick();
      chk("f2_step", 32'(step_cnt), 32'(i));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk_all_zero("abort");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_noreq", 32'(tb_req), 0);
      chk("abort_idle", 32'(busy), 0);
    end

    in_valid = 1'b1;
    tick();
    chk("f3_init", 32'(acs_init), 1);
    tick();
    for (int i = 0; i < 64; i++) begin
      rx_pair_in = pat(63 - i);
      tick();
      chk("f3_step", 32'(step_cnt), 32'(i));
      chk("f3_pair", 32'(rx_pair), 32'(pat(63 - i)));
    end
    in_valid = 1'b0;
    tick();
    chk("f3_req", 32'(tb_req), 1);
    tb_ack = 1'b1;
    tick();
    tb_ack = 1'b0;
    chk("f3_done_req", 32'(tb_req), 0);
    chk("f3_done_busy", 32'(busy), 0);
    chk("f3_done_step", 32'(step_cnt), 63);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
